dsp_lut_iq_mc: RTL and testbench

DSP_LUT_IQ_MC -- requirements
Module: dsp_lut_iq_mc

---
 rtl/dsp_lut_iq_mc.sv | 182 ++++++++++++++++++
 tb/tb_dsp_lut_iq_mc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_lut_iq_mc.sv
// Multi-channel I/Q shaper: per-channel limiter, shared double-buffered magnitude LUT, or mute.
// Three-stage pipeline; the LUT bank is latched with each sample so a swap never splits one sample.
module dsp_lut_iq_mc #(
   parameter int NCH       = 2,
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [NCH*IN_WIDTH-1:0]  i_in,
   input  logic [NCH*IN_WIDTH-1:0]  q_in,
   input  logic [2*NCH-1:0]         mode,
   input  logic                     cfg_wr,
   input  logic                     cfg_clr,
   input  logic [OUT_WIDTH-2:0]     cfg_data,
   input  logic                     swap_req,
   output logic                     swap_ack,
   output logic                     active_bank,
   output logic [NCH*OUT_WIDTH-1:0] i_out,
   output logic [NCH*OUT_WIDTH-1:0] q_out,
   output logic                     valid,
   output logic [15:0]              clip_cnt
);
   localparam int MW    = IN_WIDTH - 1;
   localparam int DEPTH = 2 ** MW;
   localparam int NL    = 2 * NCH;
   localparam logic [MW-1:0] LIM = MW'(2 ** (OUT_WIDTH - 1) - 1);

   logic [OUT_WIDTH-2:0] tbl_q [2][DEPTH];
   logic [MW-1:0]        wr_ptr_q;
   logic                 bank_q;
   logic                 swap_ack_q;

   logic                 v1_q;
   logic                 bank1_q;
   logic [MW-1:0]        mag_q [NL];
   logic [MW-1:0]        mag_d [NL];
   logic [NL-1:0]        neg_q;
   logic [NL-1:0]        neg_d;
   logic [2*NCH-1:0]     mode1_q;

   logic                 v2_q;
   logic [OUT_WIDTH-1:0] res_q [NL];
   logic [OUT_WIDTH-1:0] res_d [NL];
   logic [15:0]          nclip_q;
   logic [15:0]          nclip_d;
   logic [1:0]           lm;
   logic [OUT_WIDTH-2:0] rm;

   logic                     valid_q;
   logic [NCH*OUT_WIDTH-1:0] i_out_q;
   logic [NCH*OUT_WIDTH-1:0] q_out_q;
   logic [15:0]              clip_cnt_q;
   logic [16:0]              clip_sum;

   // The most negative input has no positive twin; it folds onto the top table entry.
   function automatic logic [MW-1:0] abs_sat(input logic [IN_WIDTH-1:0] x);
      logic [IN_WIDTH-1:0] n;
      n = x[IN_WIDTH-1] ? (~x + 1'b1) : x;
      return n[IN_WIDTH-1] ? '1 : n[MW-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         bank_q     <= 1'b0;
         swap_ack_q <= 1'b0;
      end else begin
         swap_ack_q <= swap_req;
         if (swap_req)
            bank_q <= ~bank_q;
         if (swap_req || cfg_clr)
            wr_ptr_q <= '0;
         else if (cfg_wr)
            wr_ptr_q <= wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (cfg_wr && !cfg_clr)
         tbl_q[~bank_q][wr_ptr_q] <= cfg_data;
   end

   always_comb begin
      for (int n = 0; n < NCH; n++) begin
         mag_d[2*n]   = abs_sat(i_in[n*IN_WIDTH +: IN_WIDTH]);
         neg_d[2*n]   = i_in[n*IN_WIDTH + IN_WIDTH - 1];
         mag_d[2*n+1] = abs_sat(q_in[n*IN_WIDTH +: IN_WIDTH]);
         neg_d[2*n+1] = q_in[n*IN_WIDTH + IN_WIDTH - 1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         bank1_q <= 1'b0;
         neg_q   <= '0;
         mode1_q <= '0;
         for (int l = 0; l < NL; l++)
            mag_q[l] <= '0;
      end else begin
         v1_q <= we;
         if (we) begin
            bank1_q <= bank_q;
            neg_q   <= neg_d;
            mode1_q <= mode;
            for (int l = 0; l < NL; l++)
               mag_q[l] <= mag_d[l];
         end
      end
   end

   always_comb begin
      nclip_d = '0;
      lm      = '0;
      rm      = '0;
      for (int l = 0; l < NL; l++) begin
         lm = mode1_q[(l/2)*2 +: 2];
         rm = '0;
         case (lm)
            2'd1: rm = tbl_q[bank1_q][mag_q[l]];
            2'd2: rm = '0;
            default: begin
               if (mag_q[l] > LIM) begin
                  rm      = '1;
                  nclip_d = nclip_d + 16'd1;
               end else begin
                  rm = mag_q[l][OUT_WIDTH-2:0];
               end
            end
         endcase
         res_d[l] = neg_q[l] ? -{1'b0, rm} : {1'b0, rm};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2_q    <= 1'b0;
         nclip_q <= '0;
         for (int l = 0; l < NL; l++)
            res_q[l] <= '0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            nclip_q <= nclip_d;
            for (int l = 0; l < NL; l++)
               res_q[l] <= res_d[l];
         end
      end
   end

   assign clip_sum = {1'b0, clip_cnt_q} + {1'b0, nclip_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         i_out_q    <= '0;
         q_out_q    <= '0;
         clip_cnt_q <= '0;
      end else begin
         valid_q <= v2_q;
         if (v2_q) begin
            for (int n = 0; n < NCH; n++) begin
               i_out_q[n*OUT_WIDTH +: OUT_WIDTH] <= res_q[2*n];
               q_out_q[n*OUT_WIDTH +: OUT_WIDTH] <= res_q[2*n+1];
            end
         end
         if (cfg_clr)
            clip_cnt_q <= '0;
         else if (v2_q)
            clip_cnt_q <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
      end
   end

   assign swap_ack    = swap_ack_q;
   assign active_bank = bank_q;
   assign i_out       = i_out_q;
   assign q_out       = q_out_q;
   assign valid       = valid_q;
   assign clip_cnt    = clip_cnt_q;
endmodule

// File: tb/tb_dsp_lut_iq_mc.sv
// Directed bench for dsp_lut_iq_mc at default parameters (2 channels, 8-bit in, 4-bit out).
module tb_dsp_lut_iq_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic        cfg_wr = 1'b0;
   logic        cfg_clr = 1'b0;
   logic        swap_req = 1'b0;
   logic [15:0] i_in = '0;
   logic [15:0] q_in = '0;
   logic [3:0]  mode = '0;
   logic [2:0]  cfg_data = '0;
   logic        swap_ack;
   logic        active_bank;
   logic        valid;
   logic [7:0]  i_out;
   logic [7:0]  q_out;
   logic [15:0] clip_cnt;

   int   checks = 0;
   int   errors = 0;
   logic mb = 1'b0;
   int   qj[$];
   int   qm[$];
   int   j, m, s, seen;

   logic signed [3:0] oi0, oq0, oi1, oq1;
   assign oi0 = i_out[3:0];
   assign oq0 = q_out[3:0];
   assign oi1 = i_out[7:4];
   assign oq1 = q_out[7:4];

   always #5 clk = ~clk;

   dsp_lut_iq_mc dut (
      .clk(clk), .rst(rst), .we(we), .i_in(i_in), .q_in(q_in), .mode(mode),
      .cfg_wr(cfg_wr), .cfg_clr(cfg_clr), .cfg_data(cfg_data), .swap_req(swap_req),
      .swap_ack(swap_ack), .active_bank(active_bank), .i_out(i_out), .q_out(q_out),
      .valid(valid), .clip_cnt(clip_cnt)
   );

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i0, input int q0, input int i1, input int q1, input logic [3:0] md);
      we   = 1'b1;
      i_in = {8'(i1), 8'(i0)};
      q_in = {8'(q1), 8'(q0)};
      mode = md;
   endtask

   task automatic send(input string tag, input int i0, input int q0, input int i1, input int q1,
                       input logic [3:0] md, input int e0, input int e1, input int e2, input int e3);
      int lat;
      drive(i0, q0, i1, q1, md);
      tick;
      we   = 1'b0;
      i_in = 16'($urandom);
      q_in = 16'($urandom);
      mode = 4'($urandom);
      lat  = 1;
      while (!valid && lat < 8) begin
         tick;
         lat++;
      end
      chk({tag, " latency"}, lat, 3);
      chk({tag, " i0"}, int'(oi0), e0);
      chk({tag, " q0"}, int'(oq0), e1);
      chk({tag, " i1"}, int'(oi1), e2);
      chk({tag, " q1"}, int'(oq1), e3);
      tick;
      chk({tag, " valid pulse"}, int'(valid), 0);
      chk({tag, " hold i0"}, int'(oi0), e0);
      chk({tag, " hold q1"}, int'(oq1), e3);
   endtask

   task automatic wr(input int d);
      cfg_wr   = 1'b1;
      cfg_data = 3'(d);
      tick;
      cfg_wr   = 1'b0;
   endtask

   task automatic clr;
      cfg_clr = 1'b1;
      tick;
      cfg_clr = 1'b0;
   endtask

   task automatic swap;
      swap_req = 1'b1;
      tick;
      swap_req = 1'b0;
      mb = ~mb;
      chk("swap_ack", int'(swap_ack), 1);
      chk("swap bank", int'(active_bank), int'(mb));
      tick;
      chk("swap_ack pulse", int'(swap_ack), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      tick;
      tick;
      chk("rst valid", int'(valid), 0);
      chk("rst i_out", int'(i_out), 0);
      chk("rst q_out", int'(q_out), 0);
      chk("rst clip", int'(clip_cnt), 0);
      chk("rst bank", int'(active_bank), 0);
      chk("rst swap_ack", int'(swap_ack), 0);
      rst = 1'b0;
      tick;

      send("lim1", 100, -128, 127, -100, 4'b1000, 7, -7, 0, 0);
      chk("lim1 clip", int'(clip_cnt), 2);
      send("lim2", 7, -8, 8, -7, 4'b1100, 7, -7, 7, -7);
      chk("lim2 clip", int'(clip_cnt), 4);
      send("lim3", -3, 0, 5, -1, 4'b0011, -3, 0, 5, -1);
      chk("lim3 clip", int'(clip_cnt), 4);
      clr;
      chk("clr clip", int'(clip_cnt), 0);

      for (int k = 0; k < 128; k++) wr(k >> 4);
      swap;
      send("lut", -37, -128, 100, 0, 4'b0101, -2, -7, 6, 0);

      for (int k = 0; k < 128; k++) wr(0);
      swap;
      for (int k = 0; k < 128; k++) wr(5);

      for (int t = 0; t < 16; t++) begin
         if (valid) begin
            if (qj.size() == 0) begin
               chk("stream spurious valid", 1, 0);
            end else begin
               j = qj.pop_front();
               m = qm.pop_front();
               s = (j % 2 != 0) ? -1 : 1;
               chk("stream latency", t, j + 3);
               chk("stream i0", int'(oi0), s * m);
               chk("stream q0", int'(oq0), -s * m);
               chk("stream i1", int'(oi1), m);
               chk("stream q1", int'(oq1), -m);
            end
         end
         if (t < 10) begin
            s = (t % 2 != 0) ? -1 : 1;
            drive(s * (t + 1), -s * (t + 1), t + 20, -(t + 20), 4'b0101);
            qj.push_back(t);
            qm.push_back((t <= 4) ? 0 : 5);
         end else begin
            we = 1'b0;
         end
         swap_req = (t == 4);
         tick;
      end
      swap_req = 1'b0;
      mb = 1'b1;
      chk("stream drained", qj.size(), 0);
      chk("stream bank", int'(active_bank), int'(mb));

      clr;
      wr(1);
      wr(2);
      cfg_clr  = 1'b1;
      cfg_wr   = 1'b1;
      cfg_data = 3'd7;
      tick;
      cfg_clr  = 1'b0;
      cfg_wr   = 1'b0;
      wr(3);
      swap;
      send("clrwr", 0, 1, 2, -1, 4'b0101, 3, 2, 0, -2);

      clr;
      for (int k = 0; k < 131; k++) wr((k < 128) ? 1 : (k < 130) ? 6 : 4);
      swap;
      send("wrap", 0, 1, 2, 3, 4'b0101, 6, 6, 4, 1);
      send("wrap top", 127, -127, -128, 0, 4'b0101, 1, -1, -1, 6);

      send("pre rst", 100, 0, 0, 0, 4'b0000, 7, 0, 0, 0);
      chk("pre rst clip", int'(clip_cnt), 1);
      drive(50, -50, 1, 1, 4'b0000);
      tick;
      drive(-60, 60, 2, 2, 4'b0000);
      tick;
      we = 1'b0;
      tick;
      chk("mid valid", int'(valid), 1);
      chk("mid i0", int'(oi0), 7);
      rst = 1'b1;
      #1;
      mb = 1'b0;
      chk("mid rst valid", int'(valid), 0);
      chk("mid rst i_out", int'(i_out), 0);
      chk("mid rst q_out", int'(q_out), 0);
      chk("mid rst clip", int'(clip_cnt), 0);
      chk("mid rst bank", int'(active_bank), int'(mb));
      tick;
      tick;
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick;
         if (valid) seen++;
      end
      chk("rst discard", seen, 0);
      send("post rst", 0, 1, 0, 1, 4'b0101, 3, 2, 3, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
